// File: rtl/read_ctrl.sv
// Read-side pointer controller for an async FIFO: read pointer, RAM address, empty/level status.
// Latency: status outputs register one rclk edge after wptr_gray_sync changes (three edges with RCTRL_SYNC_EN).
// Backpressure: a read is accepted only while rempty=0; a read while empty sets sticky rerr_underflow.
// Build option: define RCTRL_SYNC_EN to add an internal 2-flop synchroniser on wptr_gray_sync.
module read_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              ren,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel,
  output logic              rerr_underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_bin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          rd_acc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef RCTRL_SYNC_EN
  logic [PW-1:0] wsync_q1;
  logic [PW-1:0] wsync_q2;

  // Two-flop synchroniser bringing the raw write Gray pointer into rclk.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wsync_q1 <= '0;
      wsync_q2 <= '0;
    end else begin
      wsync_q1 <= wptr_gray_sync;
      wsync_q2 <= wsync_q1;
    end
  end

  assign wgray = wsync_q2;
`else
  assign wgray = wptr_gray_sync;
`endif

  assign rd_acc        = ren & ~rempty;
  assign rptr_bin_next = rptr_bin + PW'(rd_acc);
  assign rgray_next    = rptr_bin_next ^ (rptr_bin_next >> 1);
  assign wbin          = gray2bin(wgray);
  // Modulo subtraction copes with the wrap bit; a full FIFO yields exactly 2**ADDR_W.
  assign level_next    = wbin - rptr_bin_next;

  assign raddr = rptr_bin[ADDR_W-1:0];

  // Pointer and status registers; status is computed from the post-read pointer so the last read flags empty immediately.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rptr_bin       <= '0;
      rptr_gray      <= '0;
      rempty         <= 1'b1;
      ralmost_empty  <= 1'b1;
      rlevel         <= '0;
      rerr_underflow <= 1'b0;
    end else begin
      rptr_bin       <= rptr_bin_next;
      rptr_gray      <= rgray_next;
      rempty         <= (rgray_next == wgray);
      ralmost_empty  <= (level_next <= AE_LVL);
      rlevel         <= level_next;
      rerr_underflow <= rerr_underflow | (ren & rempty);
    end
  end

endmodule

// File: tb/tb_read_ctrl.sv
// Scoreboard bench for read_ctrl (default build, no internal synchroniser).
// The driver pushes the hand-computed post-edge output vector for each cycle it drives;
// a monitor on the falling edge pops and compares it against the DUT outputs.
module tb_read_ctrl;

  logic       clk;
  logic       rrst_n;
  logic       ren;
  logic [3:0] wptr;
  logic [2:0] raddr;
  logic [3:0] rptr_gray;
  logic       rempty;
  logic       ralmost_empty;
  logic [3:0] rlevel;
  logic       rerr_underflow;

  typedef struct {
    logic [13:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  read_ctrl #(.ADDR_W(3), .AE_THRESH(1)) dut (
    .rclk           (clk),
    .rrst_n         (rrst_n),
    .ren            (ren),
    .wptr_gray_sync (wptr),
    .raddr          (raddr),
    .rptr_gray      (rptr_gray),
    .rempty         (rempty),
    .ralmost_empty  (ralmost_empty),
    .rlevel         (rlevel),
    .rerr_underflow (rerr_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expected vector per falling edge once the driver has queued it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e   = exp_q.pop_front();
      act = {raddr, rptr_gray, rempty, ralmost_empty, rlevel, rerr_underflow};
      n_checks++;
      if (act === e.v) n_pass++;
      else $display("FAIL %s: got addr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b, want addr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b",
                    e.name, act[13:11], act[10:7], act[6], act[5], act[4:1], act[0],
                    e.v[13:11], e.v[10:7], e.v[6], e.v[5], e.v[4:1], e.v[0]);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic r, input logic [3:0] wg,
                      input logic [2:0] ea, input logic [3:0] eg, input logic ee,
                      input logic eae, input logic [3:0] elev, input logic euf,
                      input string name);
    exp_t e;
    @(negedge clk);
    #1;
    rrst_n = rst;
    ren    = r;
    wptr   = wg;
    e.v    = {ea, eg, ee, eae, elev, euf};
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    rrst_n = 1'b0;
    ren    = 1'b0;
    wptr   = 4'b0000;

    //    rst  ren  wgray    addr  gray     emp  ae   lvl  uf
    step(1'b0, 1'b0, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, "reset");
    // Reads while empty: underflow flags, pointer stays put.
    step(1'b1, 1'b1, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1, "underflow_1");
    step(1'b1, 1'b1, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1, "underflow_2");
    // One entry written.
    step(1'b1, 1'b0, 4'b0001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b1, "wptr_1");
    // Full: write pointer at bin 8.
    step(1'b1, 1'b0, 4'b1100, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b1, "full_8");
    // Eight back-to-back reads.
    step(1'b1, 1'b1, 4'b1100, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd7, 1'b1, "rd_1");
    step(1'b1, 1'b1, 4'b1100, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd6, 1'b1, "rd_2");
    step(1'b1, 1'b1, 4'b1100, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd5, 1'b1, "rd_3");
    step(1'b1, 1'b1, 4'b1100, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b1, "rd_4");
    step(1'b1, 1'b1, 4'b1100, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd3, 1'b1, "rd_5");
    step(1'b1, 1'b1, 4'b1100, 3'd6, 4'b0101, 1'b0, 1'b0, 4'd2, 1'b1, "rd_6");
    step(1'b1, 1'b1, 4'b1100, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd1, 1'b1, "rd_7");
    step(1'b1, 1'b1, 4'b1100, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1, "rd_8_empty");
    step(1'b1, 1'b1, 4'b1100, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd0, 1'b1, "rd_blocked");
    // Wrap: write pointer to bin 15 then bin 0.
    step(1'b1, 1'b0, 4'b1000, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd7, 1'b1, "wptr_15");
    step(1'b1, 1'b0, 4'b0000, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd8, 1'b1, "wptr_wrap_0");
    step(1'b1, 1'b1, 4'b0000, 3'd1, 4'b1101, 1'b0, 1'b0, 4'd7, 1'b1, "wrd_9");
    step(1'b1, 1'b1, 4'b0000, 3'd2, 4'b1111, 1'b0, 1'b0, 4'd6, 1'b1, "wrd_10");
    step(1'b1, 1'b1, 4'b0000, 3'd3, 4'b1110, 1'b0, 1'b0, 4'd5, 1'b1, "wrd_11");
    step(1'b1, 1'b1, 4'b0000, 3'd4, 4'b1010, 1'b0, 1'b0, 4'd4, 1'b1, "wrd_12");
    step(1'b1, 1'b1, 4'b0000, 3'd5, 4'b1011, 1'b0, 1'b0, 4'd3, 1'b1, "wrd_13");
    step(1'b1, 1'b1, 4'b0000, 3'd6, 4'b1001, 1'b0, 1'b0, 4'd2, 1'b1, "wrd_14");
    step(1'b1, 1'b1, 4'b0000, 3'd7, 4'b1000, 1'b0, 1'b1, 4'd1, 1'b1, "wrd_15");
    step(1'b1, 1'b1, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1, "wrd_wrap_empty");
    // Simultaneous read and write at level 3.
    step(1'b1, 1'b0, 4'b0010, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b1, "lvl_3");
    step(1'b1, 1'b1, 4'b0110, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b1, "simul_1");
    step(1'b1, 1'b1, 4'b0111, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd3, 1'b1, "simul_2");
    // Mid-stream reset at level 5 with underflow set.
    step(1'b1, 1'b0, 4'b0100, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd5, 1'b1, "lvl_5");
    step(1'b0, 1'b1, 4'b0100, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, "mid_reset");
    step(1'b1, 1'b0, 4'b0100, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd7, 1'b0, "post_reset");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
